// File: rtl/ks_birimi.sv
// ks_birimi: scans a register range, keeps each new running maximum and writes the kept list out.
// Optional: define KS_SIFIR_DOLDUR_EN to zero-fill the destination slots beyond the kept count.
module ks_birimi (
  input  logic        clk,
  input  logic        rst,
  input  logic        basla,
  input  logic [4:0]  kaynak_idx,
  input  logic [4:0]  hedef_idx,
  input  logic [4:0]  uzunluk,
  output logic [4:0]  yazmac_oku_idx,
  input  logic [31:0] yazmac_oku_veri,
  output logic        yazmac_yaz,
  output logic [4:0]  yazmac_yaz_idx,
  output logic [31:0] yazmac_yaz_veri,
  output logic        mesgul,
  output logic        bitti,
  output logic [4:0]  sayac
);

`ifdef KS_SIFIR_DOLDUR_EN
  typedef enum logic [2:0] {BOSTA = 3'd0, OKU = 3'd1, YAZ = 3'd2, DOLDUR = 3'd3, BITTI = 3'd4} durum_t;
`else
  typedef enum logic [2:0] {BOSTA = 3'd0, OKU = 3'd1, YAZ = 3'd2, BITTI = 3'd4} durum_t;
`endif

  durum_t      durum_q, durum_d;
  logic [4:0]  kaynak_q, kaynak_d;
  logic [4:0]  hedef_q, hedef_d;
  logic [4:0]  uzunluk_q, uzunluk_d;
  logic [31:0] max_q, max_d;
  logic [4:0]  kept_q, kept_d;
  logic [4:0]  oku_q, oku_d;
  logic [4:0]  yaz_q, yaz_d;
  logic [31:0] tampon_q [16];

  logic        tampon_we;
  logic        yaz_en;
  logic [4:0]  oku_idx;
  logic [4:0]  yaz_idx;
  logic [31:0] yaz_veri;

  always_comb begin
    durum_d   = durum_q;
    kaynak_d  = kaynak_q;
    hedef_d   = hedef_q;
    uzunluk_d = uzunluk_q;
    max_d     = max_q;
    kept_d    = kept_q;
    oku_d     = oku_q;
    yaz_d     = yaz_q;
    tampon_we = 1'b0;
    yaz_en    = 1'b0;
    oku_idx   = 5'd0;
    yaz_idx   = 5'd0;
    yaz_veri  = 32'd0;

    case (durum_q)
      BOSTA: begin
        if (basla) begin
          kaynak_d  = kaynak_idx;
          hedef_d   = hedef_idx;
          uzunluk_d = (uzunluk > 5'd16) ? 5'd16 : uzunluk;
          max_d     = 32'd0;
          kept_d    = 5'd0;
          oku_d     = 5'd0;
          yaz_d     = 5'd0;
          durum_d   = (uzunluk == 5'd0) ? BITTI : OKU;
        end
      end
      OKU: begin
        oku_idx = kaynak_q + oku_q;
        if (yazmac_oku_veri > max_q) begin
          tampon_we = 1'b1;
          max_d     = yazmac_oku_veri;
          kept_d    = kept_q + 5'd1;
        end
        oku_d = oku_q + 5'd1;
        if (oku_d == uzunluk_q) begin
          if (kept_d != 5'd0) begin
            durum_d = YAZ;
          end else begin
`ifdef KS_SIFIR_DOLDUR_EN
            durum_d = DOLDUR;
`else
            durum_d = BITTI;
`endif
          end
        end
      end
      YAZ: begin
        yaz_idx  = hedef_q + yaz_q;
        yaz_veri = tampon_q[yaz_q[3:0]];
        yaz_en   = (yaz_idx != 5'd0);
        yaz_d    = yaz_q + 5'd1;
        if (yaz_d == kept_q) begin
`ifdef KS_SIFIR_DOLDUR_EN
          durum_d = (kept_q != uzunluk_q) ? DOLDUR : BITTI;
`else
          durum_d = BITTI;
`endif
        end
      end
`ifdef KS_SIFIR_DOLDUR_EN
      DOLDUR: begin
        yaz_idx = hedef_q + yaz_q;
        yaz_en  = (yaz_idx != 5'd0);
        yaz_d   = yaz_q + 5'd1;
        if (yaz_d == uzunluk_q) durum_d = BITTI;
      end
`endif
      BITTI: begin
        durum_d = BOSTA;
      end
      default: begin
        durum_d = BOSTA;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      durum_q   <= BOSTA;
      kaynak_q  <= 5'd0;
      hedef_q   <= 5'd0;
      uzunluk_q <= 5'd0;
      max_q     <= 32'd0;
      kept_q    <= 5'd0;
      oku_q     <= 5'd0;
      yaz_q     <= 5'd0;
    end else begin
      durum_q   <= durum_d;
      kaynak_q  <= kaynak_d;
      hedef_q   <= hedef_d;
      uzunluk_q <= uzunluk_d;
      max_q     <= max_d;
      kept_q    <= kept_d;
      oku_q     <= oku_d;
      yaz_q     <= yaz_d;
    end
  end

  // Buffer holds no reset value; entries are only read back after being written this run.
  always_ff @(posedge clk) begin
    if (tampon_we) tampon_q[kept_q[3:0]] <= yazmac_oku_veri;
  end

  // Masking with rst keeps the write in the aborting cycle from reaching the register file.
  assign yazmac_yaz      = yaz_en & ~rst;
  assign yazmac_yaz_idx  = yaz_idx;
  assign yazmac_yaz_veri = yaz_veri;
  assign yazmac_oku_idx  = oku_idx;
  assign mesgul          = (durum_q != BOSTA);
  assign bitti           = (durum_q == BITTI);
  assign sayac           = kept_q;

endmodule

// File: doc/ks_birimi.md
KS_BIRIMI -- requirements
Module: ks_birimi

Interface
REQ-001 The module SHALL have these ports, one clock; reset is synchronous and active-high:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- basla  in  1  start request; sampled only in BOSTA
- kaynak_idx  in  5  first source register index (rs1)
- hedef_idx  in  5  first destination register index (rd)
- uzunluk  in  5  element count; 0 = no-op, values >16 clamped to 16
- yazmac_oku_idx  out  5  register-file read index
- yazmac_oku_veri  in  32  register-file read data, combinational, same cycle
- yazmac_yaz  out  1  register-file write enable
- yazmac_yaz_idx  out  5  register-file write index
- yazmac_yaz_veri  out  32  register-file write data
- mesgul  out  1  high in every state except BOSTA
- bitti  out  1  one-cycle completion pulse
- sayac  out  5  number of kept elements; valid from bitti until next accepted basla

Function
REQ-002 States SHALL be BOSTA, OKU, YAZ, DOLDUR (macro only), BITTI.
REQ-003 BOSTA + basla=1 SHALL latch kaynak_idx, hedef_idx, clamped uzunluk; clear max, kept count, read/write counters; go to OKU, or to BITTI if uzunluk=0.
REQ-004 basla while mesgul=1 SHALL be ignored.
REQ-005 OKU cycle i SHALL drive yazmac_oku_idx = (kaynak+i) mod 32; if yazmac_oku_veri > max (unsigned, strict), store it in buffer[kept], set max to it, increment kept.
REQ-006 OKU SHALL last exactly the latched length in cycles, then go to YAZ if kept>0, else DOLDUR/BITTI.
REQ-007 Reads SHALL all complete before any write, so overlapping source/destination ranges yield the result computed on original values.
REQ-008 YAZ cycle j SHALL assert yazmac_yaz with idx=(hedef+j) mod 32, veri=buffer[j], for j=0..kept-1.
REQ-009 Writes targeting index 0 SHALL keep yazmac_yaz=0 but still consume the cycle and advance j.
REQ-010 BITTI SHALL assert bitti=1 for exactly one cycle, drive sayac=kept, and return to BOSTA.
REQ-011 Latency from basla-accepting edge to bitti-high cycle SHALL be L + kept (+ fill cycles) + 1 cycles; L=0 gives bitti in the first cycle after acceptance.
REQ-012 yazmac_yaz SHALL be 0 outside YAZ/DOLDUR; yazmac_oku_idx SHALL be 0 outside OKU.
REQ-013 Buffer SHALL hold 16 x 32-bit entries; kept never exceeds the clamped length.

Reset
REQ-014 rst=1 at a rising edge SHALL force BOSTA with mesgul=0, bitti=0, yazmac_yaz=0, sayac=0, all indices and write data 0, regardless of state.
REQ-015 Reset mid-operation SHALL abort without further writes; no bitti pulse SHALL follow.
REQ-016 Buffer contents need not be reset.

Configuration
REQ-017 With KS_SIFIR_DOLDUR_EN defined, DOLDUR SHALL follow YAZ (or OKU if kept=0) and write 0 to (hedef+k) mod 32 for k=kept..L-1, one per cycle, index-0 writes suppressed per REQ-009, then go to BITTI.
REQ-018 Without KS_SIFIR_DOLDUR_EN, DOLDUR SHALL not exist and destination registers beyond kept SHALL be untouched.

Verification
REQ-019 x2..x6=1,2,3,4,5, rs1=2, rd=15, len=5 -> writes x15..x19=1..5, sayac=5, bitti 11 cycles after acceptance.
REQ-020 x2..x6=5,4,3,2,1, len=5 -> single write x15=5, sayac=1; with macro, x16..x19 written 0.
REQ-021 x2..x11=5,2,1,15,18,3,7,9,40,20, len=10 -> x15..x18=5,15,18,40, sayac=4, no other writes (macro off).
REQ-022 Overlap rs1=2, rd=2, x2..x4=3,1,7 -> x2=3, x3=7, sayac=2; x0-target case rs1=2, rd=31, x2..x3=1,2 -> x31=1, x0 write suppressed, sayac=2.
REQ-023 rst asserted during YAZ of REQ-019 after two writes -> no further writes, no bitti, mesgul=0 next cycle; new basla then works normally.
REQ-024 len=0 -> bitti one cycle after acceptance, sayac=0, no reads or writes; basla pulses during mesgul ignored.
